// File: rtl/y_div_pkg.sv
// Shared definitions for multi-cycle arithmetic blocks: FSM encodings,
// default operand width and a counter-sizing helper.
package y_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/y_div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module y_div_step
    import y_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic        [WIDTH:0] shifted;
    logic signed [WIDTH:0] diff;

    // rem_in < divisor always holds, so the true difference lies in
    // [-divisor, divisor-1] and fits a WIDTH+1 bit signed value exactly.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = $signed(shifted - {1'b0, divisor});
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/y_divider.sv
// Unsigned restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both sides and a single-cycle path for a zero divisor.
module y_divider
    import y_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q_bit;
    logic [WIDTH-1:0] acc_next;

    y_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q_bit)
    );

    assign acc_next = (acc_q << 1) | WIDTH'(step_q_bit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        state_d   = ST_DONE;
                        quo_d     = '1;
                        res_rem_d = dividend;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                acc_d = acc_next;
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    quo_d     = acc_next;
                    res_rem_d = step_rem;
                    dbz_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Return to IDLE only; a new accept waits for the next edge.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_y_divider.sv
// Directed bench for y_divider: vector table of hand-computed divisions plus
// hand-written sequences for stalls, ignored inputs and mid-run reset.
module tb_y_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_q   = '0;
    logic [31:0] last_r   = '0;
    logic        last_dbz = 1'b0;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    y_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Full operation: accept, wait for result (counting edges after the
    // accept edge), optionally stall, then handshake and check return to IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int hold, input bit junk);
        int lat;
        int exp_lat;
        exp_lat = edbz ? 0 : 32;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
        if (!edbz) begin
            chk("run_hold_quotient", quotient, last_q);
            chk("run_hold_remainder", remainder, last_r);
            chk("run_hold_dbz", {31'd0, div_by_zero}, {31'd0, last_dbz});
            chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (junk) begin
                in_valid = ~in_valid;
                dividend = $urandom;
                divisor  = $urandom_range(0, 3);
            end
        end
        chk("latency", lat, exp_lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_quotient", quotient, eq);
            chk("stall_remainder", remainder, er);
            chk("stall_dbz", {31'd0, div_by_zero}, {31'd0, edbz});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (junk) begin
                in_valid = ~in_valid;
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_quotient", quotient, eq);
        last_q   = eq;
        last_r   = er;
        last_dbz = edbz;
    endtask

    initial begin
        int seen_valid;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
        vecs[1]  = '{32'd81,         32'd9,          32'd9,          32'd0,   1'b0};
        vecs[2]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,   1'b1};
        vecs[3]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,   1'b0};
        vecs[4]  = '{32'd3,          32'd10,         32'd0,          32'd3,   1'b0};
        vecs[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,   1'b0};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
        vecs[7]  = '{32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,   1'b0};
        vecs[8]  = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,   1'b0};
        vecs[9]  = '{32'd1000,       32'd0,          32'hFFFFFFFF,   32'd1000, 1'b1};
        vecs[10] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0};
        vecs[11] = '{32'd50,         32'd6,          32'd8,          32'd2,   1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, 0, 1'b0);
        end

        // Result held under a 10-cycle stall with inputs wiggling.
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, 1'b1);
        // Inputs wiggling throughout RUN, then back-to-back pair.
        run_op(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 0, 1'b1);
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 1'b0);
        run_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 0, 1'b0);
        // Zero divisor with a stall.
        run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 3, 1'b1);

        // Reset in the middle of iteration 15.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd12345;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid++;
        end
        chk("aborted_no_result", seen_valid, 0);
        last_q   = '0;
        last_r   = '0;
        last_dbz = 1'b0;
        run_op(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y_divider.md
Y_DIVIDER -- requirements
Module: y_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: dividend  input  WIDTH  unsigned numerator.
REQ-007 SHALL have port: divisor  input  WIDTH  unsigned denominator.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port: div_by_zero  output  1  result came from a zero divisor.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE, as a function of state alone.
REQ-015 SHALL accept operands on an edge where in_valid=1 and in_ready=1, latching dividend and divisor internally.
REQ-016 SHALL go from IDLE to RUN on accept when divisor is nonzero, clearing the partial remainder and the iteration counter.
REQ-017 SHALL perform one restoring shift-subtract step per edge in RUN, MSB first:
- shift partial remainder left, bringing in the next dividend bit;
- subtract divisor;
- if the result is non-negative, keep the difference and shift in quotient bit 1;
- otherwise keep the shifted value and shift in 0.
REQ-018 SHALL move from RUN to DONE on the edge completing iteration WIDTH-1, so out_valid rises exactly WIDTH edges after the accept edge (32 for the default).
REQ-019 SHALL, on accept with divisor=0, go directly from IDLE to DONE, with out_valid high one edge after accept:
- quotient = all ones;
- remainder = dividend;
- div_by_zero = 1.
REQ-020 SHALL assert out_valid only in DONE.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 SHALL return from DONE to IDLE on an edge where out_valid=1 and out_ready=1.
REQ-023 SHALL not accept new operands in that same edge, so in_ready rises the cycle after the result handshake.
REQ-024 SHALL ignore in_valid, dividend and divisor in RUN and DONE, with no effect on the computation in progress.
REQ-025 SHALL keep quotient, remainder and div_by_zero at their last result values in IDLE and RUN, updating them only on entry to DONE.
REQ-026 SHALL clear div_by_zero to 0 for every nonzero-divisor result.
REQ-027 SHALL size the iteration counter to ceil(log2(WIDTH)) bits with no wrap beyond WIDTH-1.
REQ-028 SHALL compute the subtraction at WIDTH+1 bits, so a partial remainder with its MSB set is handled correctly (e.g. dividend 0xFFFFFFFF).

Reset
REQ-029 SHALL, while rst_n=0, immediately force:
- state = IDLE;
- in_ready = 1 once released;
- out_valid = 0;
- quotient = 0, remainder = 0, div_by_zero = 0;
- counter and internal registers = 0.
REQ-030 SHALL abort any in-progress RUN or DONE on reset without emitting a result; the first edge after release behaves as IDLE.

Structure
REQ-031 SHALL take FSM state encodings and the default WIDTH from a shared package (y_div_pkg), which also serves later multi-cycle arithmetic blocks.
REQ-032 SHALL place one restoring iteration in a purely combinational sub-module y_div_step:
- inputs: partial remainder, next dividend bit, divisor;
- outputs: new partial remainder and quotient bit.
REQ-033 SHALL keep all sequential logic (FSM, counter, operand/result registers) in y_divider.

Verification
REQ-034 SHALL cover: dividend=100, divisor=7 -> out_valid exactly 32 edges after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-035 SHALL cover: dividend=5, divisor=0 -> out_valid one edge after accept, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-036 SHALL cover: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; and dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles after out_valid -> outputs unchanged for all 10 cycles; in_ready=0 throughout; in_ready=1 the cycle after the out_ready handshake.
REQ-038 SHALL cover: in_valid toggled with new operands during RUN -> result unchanged; back-to-back pair 100/7 then 81/9 -> 14 r2, then 9 r0.
REQ-039 SHALL cover: rst_n asserted at iteration 15 of a RUN -> out_valid=0 and in_ready=1 after release; next operation 50/6 -> quotient=8, remainder=2.
